// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state type, index-width helper and default widths for the memory port arbiter
package mem_arb_pkg;
   localparam int DEF_ADDR_W = 32;
   localparam int DEF_LINE_W = 256;
   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, req vector + last winner -> next winner index and valid
module rr_pick
   import mem_arb_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int IW     = idx_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IW-1:0]     last,
   output logic [IW-1:0]     grant,
   output logic              valid
);
   logic [IW-1:0] c;
   always_comb begin
      grant = '0;
      valid = 1'b0;
      c     = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         c = IW'((int'(last) + k) % NUM_CH);
         if (req[c]) begin
            grant = c;
            valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one line-wide enable/ack memory port among NUM_CH requesters, with sticky timeout
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter  int NUM_CH  = 2,
   parameter  int ADDR_W  = DEF_ADDR_W,
   parameter  int LINE_W  = DEF_LINE_W,
   parameter  int TIMEOUT = 64,
   localparam int IW      = idx_w(NUM_CH)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_CH-1:0]        ch_enable_i,
   input  logic [NUM_CH-1:0]        ch_write_i,
   input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
   input  logic [NUM_CH*LINE_W-1:0] ch_data_i,
   output logic [LINE_W-1:0]        ch_data_o,
   output logic [NUM_CH-1:0]        ch_ack_o,
   input  logic [LINE_W-1:0]        mem_data_i,
   input  logic                     mem_ack_i,
   output logic [LINE_W-1:0]        mem_data_o,
   output logic [ADDR_W-1:0]        mem_addr_o,
   output logic                     mem_enable_o,
   output logic                     mem_write_o,
   output logic [IW-1:0]            grant_o,
   output logic                     busy_o,
   output logic                     timeout_o
);
   localparam int CW = $clog2(TIMEOUT + 1);
   state_t        state, state_n;
   logic [IW-1:0] last, pick;
   logic          pick_valid;
   logic [CW-1:0] wait_cnt;
   logic [ADDR_W-1:0] addr_a [NUM_CH];
   logic [LINE_W-1:0] data_a [NUM_CH];
   for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
      assign addr_a[g] = ch_addr_i[g*ADDR_W +: ADDR_W];
      assign data_a[g] = ch_data_i[g*LINE_W +: LINE_W];
   end
   rr_pick #(.NUM_CH(NUM_CH)) u_pick (
      .req   (ch_enable_i),
      .last  (last),
      .grant (pick),
      .valid (pick_valid)
   );
   always_comb begin
      state_n = (state == IDLE)  ? (pick_valid ? GRANT : IDLE) :
                (state == GRANT) ? (mem_ack_i ? RELEASE : GRANT) : IDLE;
   end
   assign ch_ack_o  = (state == GRANT && mem_ack_i) ? NUM_CH'(1) << grant_o : '0;
   assign ch_data_o = mem_data_i;
   assign busy_o    = (state != IDLE);
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         last         <= IW'(NUM_CH - 1);
         grant_o      <= '0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
         mem_enable_o <= 1'b0;
         mem_write_o  <= 1'b0;
         wait_cnt     <= '0;
         timeout_o    <= 1'b0;
      end else begin
         state <= state_n;
         if (state == IDLE && pick_valid) begin
            grant_o      <= pick;
            last         <= pick;
            mem_addr_o   <= addr_a[pick];
            mem_data_o   <= data_a[pick];
            mem_write_o  <= ch_write_i[pick];
            mem_enable_o <= 1'b1;
            wait_cnt     <= '0;
         end
         if (state == GRANT && mem_ack_i) begin
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
         end
         if (state == GRANT && !mem_ack_i) begin
            wait_cnt <= (int'(wait_cnt) >= TIMEOUT) ? wait_cnt : wait_cnt + 1'b1;
            if (int'(wait_cnt) + 1 >= TIMEOUT) timeout_o <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
   localparam int NCH = 2;
   localparam int TO  = 8;
   logic           clk = 1'b0;
   logic           rst_i = 1'b1;
   logic [1:0]     ch_enable_i = '0;
   logic [1:0]     ch_write_i = '0;
   logic [63:0]    ch_addr_i = '0;
   logic [511:0]   ch_data_i = '0;
   logic [255:0]   ch_data_o;
   logic [1:0]     ch_ack_o;
   logic [255:0]   mem_data_i = '0;
   logic           mem_ack_i = 1'b0;
   logic [255:0]   mem_data_o;
   logic [31:0]    mem_addr_o;
   logic           mem_enable_o, mem_write_o, busy_o, timeout_o;
   logic [0:0]     grant_o;
   int n_chk = 0, n_err = 0, cyc = 0, c_ack = 0, lat = 0;
   logic [1:0]     last_ack = '0;
   bit             m_active, m_write, m_to;
   int             m_gap, m_last, m_cur, m_grant, m_wait;
   logic [31:0]    m_addr;
   logic [255:0]   m_data;
   always #5 clk = ~clk;
   mem_port_arbiter #(.NUM_CH(NCH), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst_i), .ch_enable_i(ch_enable_i), .ch_write_i(ch_write_i),
      .ch_addr_i(ch_addr_i), .ch_data_i(ch_data_i), .ch_data_o(ch_data_o), .ch_ack_o(ch_ack_o),
      .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .grant_o(grant_o),
      .busy_o(busy_o), .timeout_o(timeout_o)
   );
   task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, act, exp);
      end
   endtask
   function automatic logic [255:0] rand_line();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction
   task automatic req(input int c, input logic w, input logic [31:0] a, input logic [255:0] d);
      ch_enable_i[c] = 1'b1;
      ch_write_i[c] = w;
      ch_addr_i[c*32 +: 32] = a;
      ch_data_i[c*256 +: 256] = d;
   endtask
   task automatic post_check();
      check("mem_enable", mem_enable_o, m_active);
      check("mem_write", mem_write_o, m_active && m_write);
      check("busy", busy_o, m_active || m_gap > 0);
      check("timeout", timeout_o, m_to);
      check("grant", grant_o, m_grant);
      if (m_active) begin
         check("mem_addr", mem_addr_o, m_addr);
         check("mem_data", mem_data_o, m_data);
      end
   endtask
   task automatic step();
      logic [1:0] exp_ack;
      int c;
      #1;
      exp_ack = (m_active && mem_ack_i) ? (2'b01 << m_cur) : 2'b00;
      last_ack = ch_ack_o;
      check("ch_ack", ch_ack_o, exp_ack);
      check("ch_data", ch_data_o, mem_data_i);
      if (m_active) begin
         if (mem_ack_i) begin
            m_active = 0;
            m_gap = 1;
         end else begin
            m_wait++;
            if (m_wait >= TO) m_to = 1;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else begin
         for (int k = 1; k <= NCH; k++) begin
            c = (m_last + k) % NCH;
            if (!m_active && ch_enable_i[c]) begin
               m_active = 1;
               m_cur = c;
               m_grant = c;
               m_last = c;
               m_wait = 0;
               m_addr = ch_addr_i[c*32 +: 32];
               m_data = ch_data_i[c*256 +: 256];
               m_write = ch_write_i[c];
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      post_check();
   endtask
   task automatic do_reset();
      rst_i = 1'b1;
      mem_ack_i = 1'b0;
      ch_enable_i = '0;
      @(posedge clk);
      #1;
      cyc = 0;
      rst_i = 1'b0;
      m_active = 0; m_write = 0; m_to = 0; m_gap = 0;
      m_last = NCH - 1; m_cur = 0; m_grant = 0; m_wait = 0;
      last_ack = '0;
      post_check();
      check("rst_ack", ch_ack_o, 2'b00);
      check("rst_addr", mem_addr_o, 32'h0);
      check("rst_data", mem_data_o, 256'h0);
   endtask
   initial begin
      do_reset();
      // single read, memory latency 10
      req(0, 1'b0, 32'h0000_0400, rand_line());
      step();
      check("rd_issue", mem_enable_o, 1'b1);
      for (int i = 0; i < 9; i++) step();
      mem_ack_i = 1'b1;
      mem_data_i = rand_line();
      step();
      check("rd_ack", last_ack, 2'b01);
      mem_ack_i = 1'b0;
      ch_enable_i = '0;
      step();
      check("rd_release", mem_enable_o, 1'b0);
      step();
      // simultaneous requests from reset
      do_reset();
      req(0, 1'b0, 32'h0000_1000, rand_line());
      req(1, 1'b0, 32'h0000_2000, rand_line());
      step();
      check("sim_first", grant_o, 1'b0);
      step();
      mem_ack_i = 1'b1;
      c_ack = cyc;
      step();
      mem_ack_i = 1'b0;
      ch_enable_i[0] = 1'b0;
      for (int i = 0; i < 10 && !mem_enable_o; i++) step();
      check("sim_gap", cyc - c_ack, 3);
      check("sim_second", grant_o, 1'b1);
      mem_ack_i = 1'b1;
      step();
      mem_ack_i = 1'b0;
      req(0, 1'b0, 32'h0000_3000, rand_line());
      req(1, 1'b0, 32'h0000_4000, rand_line());
      step();
      step();
      check("alt_third", grant_o, 1'b0);
      mem_ack_i = 1'b1;
      step();
      mem_ack_i = 1'b0;
      ch_enable_i[0] = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check("alt_fourth", grant_o, 1'b1);
      mem_ack_i = 1'b1;
      step();
      mem_ack_i = 1'b0;
      ch_enable_i = '0;
      step();
      // write on ch1, then stray acks in RELEASE and IDLE
      do_reset();
      req(1, 1'b1, 32'h0000_0800, {32{8'hA5}});
      step();
      check("wr_strobe", mem_write_o, 1'b1);
      check("wr_addr", mem_addr_o, 32'h0000_0800);
      for (int i = 0; i < 4; i++) step();
      mem_ack_i = 1'b1;
      step();
      check("wr_ack", last_ack, 2'b10);
      ch_enable_i = '0;
      step();
      check("stray_release", last_ack, 2'b00);
      step();
      check("stray_idle", busy_o, 1'b0);
      mem_ack_i = 1'b0;
      step();
      // timeout with a memory that never acks, then reset mid-transaction
      do_reset();
      req(0, 1'b0, 32'h0000_0C00, rand_line());
      step();
      for (int i = 0; i < TO - 1; i++) step();
      check("to_before", timeout_o, 1'b0);
      step();
      check("to_rise", timeout_o, 1'b1);
      for (int i = 0; i < 4; i++) step();
      check("to_sticky", timeout_o, 1'b1);
      do_reset();
      check("to_cleared", timeout_o, 1'b0);
      // ch0 abandons mid-GRANT; ch1 asks during RELEASE
      req(0, 1'b0, 32'h0000_1400, rand_line());
      step();
      step();
      ch_enable_i[0] = 1'b0;
      step();
      step();
      mem_ack_i = 1'b1;
      step();
      check("abandon_ack", last_ack, 2'b01);
      mem_ack_i = 1'b0;
      req(1, 1'b0, 32'h0000_1800, rand_line());
      step();
      check("abandon_gap", mem_enable_o, 1'b0);
      step();
      step();
      check("abandon_next", grant_o, 1'b1);
      // randomized traffic
      do_reset();
      lat = 0;
      for (int n = 0; n < 1500; n++) begin
         for (int c = 0; c < NCH; c++) begin
            if (last_ack[c]) ch_enable_i[c] = 1'b0;
            else if (!ch_enable_i[c] && $urandom_range(2) == 0)
               req(c, 1'($urandom_range(1)), $urandom, rand_line());
         end
         mem_data_i = rand_line();
         if (mem_enable_o) begin
            lat++;
            mem_ack_i = (lat >= 5) || ($urandom_range(3) == 0);
         end else begin
            lat = 0;
            mem_ack_i = ($urandom_range(4) == 0);
         end
         if (mem_ack_i) lat = 0;
         step();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
